// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the register-file writeback path: datapath widths,
// register count and the fixed index assignment of writeback requesters.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN     = 32;   // register data width
    localparam int AW       = 5;    // register address width
    localparam int NUM_REGS = 32;   // architectural registers (x0..x31)

    // Writeback requester slots on the arbiter
    localparam int REQ_ALU  = 0;
    localparam int REQ_LSU  = 1;
    localparam int REQ_MDU  = 2;
    localparam int NREQ_DEF = 3;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts one past the
// last winner (ptr) and wraps modulo N; the first requester found wins.
// The pointer register is owned by the instantiating module.
//
// Ports
//   req        in   N    request vector
//   ptr        in   PW   index of the previous winner
//   grant      out  N    one-hot grant, all zero when no request
//   grant_idx  out  PW   binary index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    always_comb begin
        logic w_found;
        int   w_idx;
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        // k runs 1..N so the previous winner is examined last
        for (int k = 1; k <= N; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!w_found && req[w_idx]) begin
                w_found          = 1'b1;
                grant[w_idx]     = 1'b1;
                grant_idx        = PW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port between NREQ writeback
// requesters with round-robin arbitration and valid/ready handshakes, and
// keeps the pending-write scoreboard used for hazard stalls.
//
// Ports
//   clk         in   1          clock, posedge
//   reset       in   1          synchronous, active-high
//   req_valid   in   NREQ       requester i holds a write
//   req_addr    in   NREQ*AW    rd of requester i, slice [i*AW +: AW]
//   req_data    in   NREQ*XLEN  data of requester i, slice [i*XLEN +: XLEN]
//   req_ready   out  NREQ       one-hot grant (valid&ready = accepted)
//   mark_valid  in   1          issue marks a register pending
//   mark_addr   in   AW         register to mark
//   WE3/A3/WD3  out             register file write port (registered)
//   pending     out  NUM_REGS   bit r set while a write to xr is outstanding
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = regfile_pkg::NREQ_DEF,
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int AW   = regfile_pkg::AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 mark_valid,
    input  logic [AW-1:0]        mark_addr,
    output logic                 WE3,
    output logic [AW-1:0]        A3,
    output logic [XLEN-1:0]      WD3,
    output logic [NUM_REGS-1:0]  pending
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]       r_ptr;
    logic                r_we3;
    logic [AW-1:0]       r_a3;
    logic [XLEN-1:0]     r_wd3;
    logic [NUM_REGS-1:0] r_pending;

    logic [NREQ-1:0]     w_grant;
    logic [PW-1:0]       w_grant_idx;
    logic                w_any_grant;
    logic [AW-1:0]       w_sel_addr;
    logic [XLEN-1:0]     w_sel_data;
    logic [NUM_REGS-1:0] w_pending_nxt;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Nothing is accepted while reset is held, so no handshake can be lost.
    assign w_any_grant = |w_grant & ~reset;
    assign req_ready   = reset ? '0 : w_grant;

    assign w_sel_addr  = req_addr[w_grant_idx*AW +: AW];
    assign w_sel_data  = req_data[w_grant_idx*XLEN +: XLEN];

    // Round-robin pointer: remembers the last accepted requester.
    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= PW'(NREQ - 1);
        else if (w_any_grant)
            r_ptr <= w_grant_idx;
    end

    // Registered write stage. A3/WD3 hold on idle cycles; writes to x0
    // complete the handshake but never raise the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else if (w_any_grant) begin
            r_we3 <= (w_sel_addr != '0);
            r_a3  <= w_sel_addr;
            r_wd3 <= w_sel_data;
        end else begin
            r_we3 <= 1'b0;
        end
    end

    // A write registered just before reset would otherwise commit on the
    // reset edge; masking with reset drops it.
    assign WE3 = r_we3 & ~reset;
    assign A3  = r_a3;
    assign WD3 = r_wd3;

    // Scoreboard: the clear tracks the commit edge; a same-cycle mark of
    // the same register is applied after the clear so it wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_we3)
            w_pending_nxt[r_a3] = 1'b0;
        if (mark_valid && mark_addr != '0)
            w_pending_nxt[mark_addr] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_pending <= '0;
        else
            r_pending <= w_pending_nxt;
    end

    assign pending = r_pending;

endmodule
